// File: rtl/axis_input_rx_cu_pkg.sv
// Shared definitions for the AXI-Stream input receive control unit:
// FSM state encoding and default counter widths.
package axis_input_rx_cu_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned COL_W_DEF = 8;
    localparam int unsigned ROW_W_DEF = 8;
    localparam int unsigned CH_W_DEF  = 8;

    typedef enum logic [STATE_W-1:0] {
        StIdle      = 4'd0,
        StRecvRow   = 4'd1,
        StIssue     = 4'd2,
        StGuard     = 4'd3,
        StWaitIdle  = 4'd4,
        StIssueLast = 4'd5,
        StGuardLast = 4'd6,
        StWaitLast  = 4'd7
    } rx_state_e;

endpackage

// File: rtl/axis_input_rx_cu_row_counter.sv
// Column/row bookkeeping for the receive CU: write column, row index, mod-3 line
// buffer select, end-of-row detection and sticky tlast framing error.
module axis_rx_row_counter
    import axis_input_rx_cu_pkg::*;
#(
    parameter int unsigned COL_W = COL_W_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             frame_start_i,
    input  logic             chan_start_i,
    input  logic             beat_i,
    input  logic             tlast_i,
    input  logic             row_inc_i,
    input  logic [COL_W-1:0] img_width_i,
    output logic [COL_W-1:0] col_cnt_o,
    output logic [ROW_W-1:0] row_cnt_o,
    output logic [1:0]       row_sel_o,
    output logic             end_of_row_o,
    output logic             err_tlast_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             eor;

    assign eor = (col_q == img_width_i - COL_W'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        sel_d = sel_q;
        err_d = err_q;
        if (frame_start_i || chan_start_i) begin
            col_d = '0;
            row_d = '0;
            sel_d = 2'd0;
            if (frame_start_i) begin
                err_d = 1'b0;
            end
        end else begin
            if (beat_i) begin
                col_d = eor ? '0 : col_q + COL_W'(1);
                // Row length is always by count; tlast only feeds the error flag.
                if (eor != tlast_i) begin
                    err_d = 1'b1;
                end
            end
            if (row_inc_i) begin
                row_d = row_q + ROW_W'(1);
                sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
            sel_q <= 2'd0;
            err_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            sel_q <= sel_d;
            err_q <= err_d;
        end
    end

    assign col_cnt_o    = col_q;
    assign row_cnt_o    = row_q;
    assign row_sel_o    = sel_q;
    assign end_of_row_o = eor;
    assign err_tlast_o  = err_q;

endmodule

// File: rtl/axis_input_rx_cu.sv
// AXI-Stream slave control unit: writes feature-map rows into three rotating line
// BRAMs and issues per-row commands to the PE/output-buffer CU, looping over channels.
module axis_input_rx_cu
    import axis_input_rx_cu_pkg::*;
#(
    parameter int unsigned COL_W = COL_W_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF,
    parameter int unsigned CH_W  = CH_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [COL_W-1:0] img_width_i,
    input  logic [ROW_W-1:0] img_height_i,
    input  logic [CH_W-1:0]  n_channels_i,
    input  logic             s_axis_tvalid_i,
    input  logic             s_axis_tlast_i,
    output logic             s_axis_tready_o,
    input  logic             pe_with_buffers_idle_i,
    output logic             ena_input_bram_o,
    output logic             wea_input_bram_o,
    output logic [COL_W-1:0] input_bram_addr_o,
    output logic [1:0]       row_sel_o,
    output logic             stream_mid_row_o,
    output logic             stream_last_row_o,
    output logic             last_channel_o,
    output logic             frame_done_o,
    output logic             err_tlast_o,
    output logic             busy_o
);

    rx_state_e        state_q, state_d;
    logic [COL_W-1:0] width_q, width_d;
    logic [ROW_W-1:0] height_q, height_d;
    logic [CH_W-1:0]  nch_q, nch_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             last_ch_q, last_ch_d;

    logic             frame_start, chan_start, row_inc, ch_inc, beat, eor;
    logic [ROW_W-1:0] row_cnt;

    assign beat = s_axis_tready_o & s_axis_tvalid_i;

    axis_rx_row_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_row_counter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .frame_start_i (frame_start),
        .chan_start_i  (chan_start),
        .beat_i        (beat),
        .tlast_i       (s_axis_tlast_i),
        .row_inc_i     (row_inc),
        .img_width_i   (width_q),
        .col_cnt_o     (input_bram_addr_o),
        .row_cnt_o     (row_cnt),
        .row_sel_o     (row_sel_o),
        .end_of_row_o  (eor),
        .err_tlast_o   (err_tlast_o)
    );

    always_comb begin
        state_d           = state_q;
        s_axis_tready_o   = 1'b0;
        stream_mid_row_o  = 1'b0;
        stream_last_row_o = 1'b0;
        frame_done_o      = 1'b0;
        frame_start       = 1'b0;
        chan_start        = 1'b0;
        row_inc           = 1'b0;
        ch_inc            = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    frame_start = 1'b1;
                    state_d     = StRecvRow;
                end
            end
            StRecvRow: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i && eor) begin
                    // First row of a channel only primes the line buffers.
                    if (row_cnt == '0) begin
                        row_inc = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                stream_mid_row_o = 1'b1;
                state_d          = StGuard;
            end
            StGuard:     state_d = StWaitIdle;
            StWaitIdle: begin
                if (pe_with_buffers_idle_i) begin
                    if (row_cnt == height_q - ROW_W'(1)) begin
                        state_d = StIssueLast;
                    end else begin
                        row_inc = 1'b1;
                        state_d = StRecvRow;
                    end
                end
            end
            StIssueLast: begin
                stream_last_row_o = 1'b1;
                state_d           = StGuardLast;
            end
            StGuardLast: state_d = StWaitLast;
            StWaitLast: begin
                if (pe_with_buffers_idle_i) begin
                    if (last_ch_q) begin
                        frame_done_o = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        chan_start = 1'b1;
                        ch_inc     = 1'b1;
                        state_d    = StRecvRow;
                    end
                end
            end
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        width_d   = frame_start ? img_width_i : width_q;
        height_d  = frame_start ? img_height_i : height_q;
        nch_d     = frame_start ? n_channels_i : nch_q;
        ch_d      = frame_start ? '0 : (ch_inc ? ch_q + CH_W'(1) : ch_q);
        last_ch_d = (ch_d == nch_d - CH_W'(1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            width_q   <= '0;
            height_q  <= '0;
            nch_q     <= '0;
            ch_q      <= '0;
            last_ch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            nch_q     <= nch_d;
            ch_q      <= ch_d;
            last_ch_q <= last_ch_d;
        end
    end

    assign ena_input_bram_o = beat;
    assign wea_input_bram_o = beat;
    assign last_channel_o   = last_ch_q;
    assign busy_o           = (state_q != StIdle);

endmodule
